// File: rtl/pc_update.sv
// Next-PC and interrupt-entry stage of the single-cycle MIPS core.
// Owns the architectural PC, synchronises irq_in and holds the pending-interrupt latch.
module pc_update #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC   = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC    = 32'h8000_0008,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_in,
  input  logic [2:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] DataBusA,
  output logic [31:0] PC,
  output logic [31:0] NewPC,
  output logic        interrupt,
  output logic        irq_pending
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   irq_s;
  logic                   irq_s_d;
  logic                   irq_edge;
  logic                   take;
  logic [31:0]            pc_next;
  logic                   unused_conba_msb;

  // Kernel bit (PC[31]) is never changed by an increment or a branch.
  assign NewPC            = {PC[31], PC[30:0] + 31'd4};
  assign unused_conba_msb = ConBA[31];

  assign irq_s     = sync[SYNC_STAGES-1];
  assign irq_edge  = irq_s & ~irq_s_d;
  assign interrupt = irq_pending & ~PC[31];
  assign take      = interrupt & (PCSrc == 3'b100);

  always_comb begin
    pc_next = NewPC;
    case (PCSrc)
      3'b001:  pc_next = BranchTaken ? {PC[31], ConBA[30:0]} : NewPC;
      3'b010:  pc_next = {PC[31:28], JT, 2'b00};
      // jr may drop to user mode but can never raise the kernel bit.
      3'b011:  pc_next = {PC[31] & DataBusA[31], DataBusA[30:0]};
      3'b100:  pc_next = ILLOP_VEC;
      3'b101:  pc_next = XADR_VEC;
      default: pc_next = NewPC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      PC          <= RESET_PC;
      sync        <= '0;
      irq_s_d     <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      PC          <= pc_next;
      sync        <= {sync[SYNC_STAGES-2:0], irq_in};
      irq_s_d     <= irq_s;
      // A new edge wins over a take so a request arriving during entry is kept.
      irq_pending <= irq_edge | (irq_pending & ~take);
    end
  end

endmodule

// File: tb/tb_pc_update.sv
// Self-checking bench for pc_update: directed literal cases plus a randomized run
// compared every cycle against a behavioural model built from the architectural rules.
module tb_pc_update;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_in;
  logic [2:0]  PCSrc;
  logic        BranchTaken;
  logic [31:0] ConBA;
  logic [25:0] JT;
  logic [31:0] DataBusA;
  logic [31:0] PC;
  logic [31:0] NewPC;
  logic        interrupt;
  logic        irq_pending;

  pc_update #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .PCSrc(PCSrc),
    .BranchTaken(BranchTaken), .ConBA(ConBA), .JT(JT), .DataBusA(DataBusA),
    .PC(PC), .NewPC(NewPC), .interrupt(interrupt), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] is the irq_in value seen at the k-th most recent active clock edge.
  logic [31:0] m_pc;
  logic        m_pend;
  logic        hist [1:S+1];
  bit          m_valid = 0;

  function automatic logic [31:0] inc_pc(input logic [31:0] p);
    logic [31:0] low;
    low = {1'b0, p[30:0]} + 32'd4;
    return {p[31], low[30:0]};
  endfunction

  always @(posedge clk) begin
    logic        m_int;
    logic        rise;
    logic [31:0] nxt;
    if (!reset) begin
      m_pc    = 32'h8000_0000;
      m_pend  = 1'b0;
      for (int k = 1; k <= S + 1; k++) hist[k] = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      m_int = m_pend && !m_pc[31];
      rise  = hist[S] && !hist[S+1];
      if      (PCSrc == 3'd1) nxt = BranchTaken ? {m_pc[31], ConBA[30:0]} : inc_pc(m_pc);
      else if (PCSrc == 3'd2) nxt = {m_pc[31:28], JT, 2'b00};
      else if (PCSrc == 3'd3) nxt = {(m_pc[31] && DataBusA[31]), DataBusA[30:0]};
      else if (PCSrc == 3'd4) nxt = 32'h8000_0004;
      else if (PCSrc == 3'd5) nxt = 32'h8000_0008;
      else                    nxt = inc_pc(m_pc);
      if (rise)                          m_pend = 1'b1;
      else if (m_int && PCSrc == 3'd4)   m_pend = 1'b0;
      m_pc = nxt;
      for (int k = S + 1; k >= 2; k--) hist[k] = hist[k-1];
      hist[1] = irq_in;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_pc", PC, m_pc);
      check("model_newpc", NewPC, inc_pc(m_pc));
      check("model_interrupt", {31'd0, interrupt}, {31'd0, m_pend && !m_pc[31]});
      check("model_pending", {31'd0, irq_pending}, {31'd0, m_pend});
    end
  end

  // ---------------- stimulus ----------------
  task automatic go(input logic [2:0] src, input logic bt = 1'b0,
                    input logic [31:0] cba = 32'h0, input logic [25:0] jt = 26'h0,
                    input logic [31:0] dba = 32'h0);
    PCSrc = src; BranchTaken = bt; ConBA = cba; JT = jt; DataBusA = dba;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; irq_in = 1'b0;
    PCSrc = 3'd0; BranchTaken = 1'b0; ConBA = '0; JT = '0; DataBusA = '0;
    @(posedge clk); #1;
    go(3'd0);
    check("reset_pc", PC, 32'h8000_0000);
    check("reset_newpc", NewPC, 32'h8000_0004);
    check("reset_pending", {31'd0, irq_pending}, 32'd0);
    check("reset_interrupt", {31'd0, interrupt}, 32'd0);
    reset = 1'b1;

    go(3'd0); check("seq_1", PC, 32'h8000_0004);
    go(3'd0); check("seq_2", PC, 32'h8000_0008);
    go(3'd0); check("seq_3", PC, 32'h8000_000C);

    go(3'd3, .dba(32'h0000_1000)); check("jr_to_user", PC, 32'h0000_1000);
    go(3'd1, .bt(1'b1), .cba(32'h0000_1040)); check("branch_taken", PC, 32'h0000_1040);
    go(3'd3, .dba(32'h0000_1000));
    go(3'd1, .bt(1'b0), .cba(32'h0000_1040)); check("branch_not_taken", PC, 32'h0000_1004);
    go(3'd3, .dba(32'h0000_2000));
    go(3'd2, .jt(26'h000_0100)); check("jump", PC, 32'h0000_0400);
    go(3'd3, .dba(32'h8000_0000)); check("jr_user_no_kernel", PC, 32'h0000_0000);
    go(3'd5); check("xadr", PC, 32'h8000_0008);
    go(3'd0); go(3'd0); check("kernel_pc", PC, 32'h8000_0010);
    go(3'd3, .dba(32'h0000_3000)); check("jr_kernel_to_user", PC, 32'h0000_3000);
    go(3'd7); check("reserved_src", PC, 32'h0000_3004);

    // user-mode interrupt, level held high
    irq_in = 1'b1;
    go(3'd0); go(3'd0);
    check("irq_lat_not_yet", {31'd0, irq_pending}, 32'd0);
    go(3'd0);
    check("irq_pending_3clk", {31'd0, irq_pending}, 32'd1);
    check("irq_interrupt", {31'd0, interrupt}, 32'd1);
    go(3'd4);
    check("irq_take_pc", PC, 32'h8000_0004);
    check("irq_take_clear", {31'd0, irq_pending}, 32'd0);
    repeat (5) go(3'd0);
    check("irq_no_retrigger", {31'd0, irq_pending}, 32'd0);
    irq_in = 1'b0;
    repeat (3) go(3'd0);

    // kernel masking, delivery on return to user
    go(3'd3, .dba(32'h8000_0100)); check("jr_kernel_stay", PC, 32'h8000_0100);
    irq_in = 1'b1;
    repeat (3) go(3'd0);
    check("kernel_pending", {31'd0, irq_pending}, 32'd1);
    check("kernel_masked", {31'd0, interrupt}, 32'd0);
    go(3'd3, .dba(32'h0000_0200));
    check("return_pc", PC, 32'h0000_0200);
    check("return_interrupt", {31'd0, interrupt}, 32'd1);

    // edge and take in the same cycle
    irq_in = 1'b0;
    repeat (3) go(3'd0);
    irq_in = 1'b1;
    go(3'd0); go(3'd0);
    go(3'd4);
    check("edge_take_pc", PC, 32'h8000_0004);
    check("edge_take_pending", {31'd0, irq_pending}, 32'd1);

    // mid-run reset
    reset = 1'b0;
    go(3'd0);
    check("midreset_pc", PC, 32'h8000_0000);
    check("midreset_pending", {31'd0, irq_pending}, 32'd0);
    reset = 1'b1;
    irq_in = 1'b0;

    // increment wraps within the low 31 bits
    go(3'd3, .dba(32'hFFFF_FFFC)); check("wrap_newpc_kernel", NewPC, 32'h8000_0000);
    go(3'd0); check("wrap_pc_kernel", PC, 32'h8000_0000);
    go(3'd3, .dba(32'h7FFF_FFFC)); check("wrap_newpc_user", NewPC, 32'h0000_0000);

    // randomized run
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) irq_in = ~irq_in;
      go(3'($urandom_range(0, 7)), 1'($urandom), $urandom, 26'($urandom), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_update.md
Name: pc_update

Overview:
- Next-PC and interrupt-entry stage of the single-cycle MIPS core.
- Owns the architectural PC register, which the fetch/decode stage reads; this block writes it.
- Each cycle it takes the decoder's PCSrc selection plus the branch, jump and register targets, and computes and registers the next PC.
- It synchronises the external interrupt line, keeps an interrupt-pending latch, and masks interrupts while in kernel mode (PC[31]=1).

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset (kernel mode).
- ILLOP_VEC, 32'h8000_0004, interrupt/illegal-op handler entry.
- XADR_VEC, 32'h8000_0008, exception handler entry.
- SYNC_STAGES, 2, flip-flop stages on irq_in (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- irq_in  input  1  raw external interrupt request, asynchronous, level.
- PCSrc  input  3  next-PC select from the control unit.
- BranchTaken  input  1  ALU result bit 0 for the current branch instruction.
- ConBA  input  32  branch target (NewPC + sign-extended offset<<2).
- JT  input  26  jump target field.
- DataBusA  input  32  rs value for jr/jalr.
- PC  output  32  current PC (registered).
- NewPC  output  32  PC + 4 with kernel bit preserved (combinational).
- interrupt  output  1  interrupt request to the control unit (combinational from registered state).
- irq_pending  output  1  pending latch state, for debug/verification.

Behaviour:
- Reset: on rising clk with reset=0, set PC=RESET_PC, clear all synchroniser flops, clear irq_pending. interrupt=0 throughout reset because PC[31]=1.
- NewPC = {PC[31], (PC[30:0]+4) mod 2^31}. Carry out of bit 30 is discarded, so the kernel bit never changes by increment.
- Next-PC select, registered on every rising clk when reset=1:
  - 000: NewPC.
  - 001: BranchTaken ? {PC[31], ConBA[30:0]} : NewPC.
  - 010: {PC[31:28], JT, 2'b00}.
  - 011: {PC[31] & DataBusA[31], DataBusA[30:0]}. User code cannot enter kernel via jr; kernel code can return to user.
  - 100: ILLOP_VEC.
  - 101: XADR_VEC.
  - 110, 111: reserved, behave as 000.
- Interrupt synchroniser: irq_in passes through SYNC_STAGES flops; irq_s is the last stage. A rising edge is detected as irq_s=1 with the previous irq_s=0, adding one more flop.
- Pending latch:
  - Set on a detected rising edge.
  - Cleared on the clock edge where interrupt=1 and PCSrc=100 (interrupt taken).
  - If an edge and a take occur in the same cycle, pending stays 1 (the new request is not lost).
  - A level held high produces a single request only.
- interrupt = irq_pending & ~PC[31].
  - Kernel mode masks delivery; pending is held until the PC returns to user mode.
- Latency: irq_in rising edge to irq_pending=1 is SYNC_STAGES+1 clocks. irq_pending to interrupt is 0 cycles (if PC[31]=0).
- PCSrc=100 while interrupt=0 (illegal op) jumps to ILLOP_VEC and does not touch pending.
- Reset asserted mid-operation overrides all other updates in that cycle. A request in flight in the synchroniser is lost.
- Saving the return address (NewPC/PC) to $26/$31 is done by the write-back mux, not by this block.

Test Plan:
- Reset then 3 cycles with PCSrc=000, reset=1 -> PC sequence 8000_0000, 8000_0004, 8000_0008, 8000_000C.
- From PC=0000_1000: branch with PCSrc=001, ConBA=0000_1040, BranchTaken=1 -> PC=0000_1040; same with BranchTaken=0 -> PC=0000_1004.
- PC=0000_2000, PCSrc=010, JT=26'h000_0100 -> PC=0000_0400. From PC=8000_0010, PCSrc=011, DataBusA=0000_3000 -> PC=0000_3000. From user PC, DataBusA=8000_0000 -> PC=0000_0000.
- User mode, irq_in 0->1 held high -> irq_pending=1 after 3 clks and interrupt=1. Control drives PCSrc=100 -> PC=8000_0004, pending=0, no re-trigger while irq_in stays high.
- Pend an interrupt while PC=8000_0100 -> interrupt stays 0. jr to 0000_0200 -> interrupt=1 on the same cycle PC=0000_0200.
- Edge detected on the same cycle as the take (PCSrc=100, interrupt=1) -> PC=8000_0004 and irq_pending remains 1. Assert reset=0 mid-sequence -> next edge PC=8000_0000, pending=0.
